// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: RV32I funct3 size/sign codes,
// the FSM state type, and the lane helpers used for byte enables, store
// data replication and load extension.
package lsu_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_DONE
  } lsu_state_t;

  // funct3[1:0] selects the access size (00 byte, 01 half, 1x word), which
  // makes the unused codes 011/110/111 behave as word accesses.
  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] a);
    case (f3[1:0])
      2'b00:   return 1'b0;
      2'b01:   return a[0];
      default: return (a != 2'b00);
    endcase
  endfunction

  function automatic logic [3:0] mask_gen(input logic [2:0] f3, input logic [1:0] a);
    case (f3[1:0])
      2'b00:   return 4'b0001 << a;
      2'b01:   return a[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] store_align(input logic [2:0] f3, input logic [31:0] sd);
    case (f3[1:0])
      2'b00:   return {4{sd[7:0]}};
      2'b01:   return {2{sd[15:0]}};
      default: return sd;
    endcase
  endfunction

  function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [1:0] a,
                                              input logic [31:0] word);
    logic [31:0] sh;
    logic [7:0]  b;
    logic [15:0] h;
    sh = word >> {a, 3'b000};
    b  = sh[7:0];
    h  = a[1] ? word[31:16] : word[15:0];
    case (f3[1:0])
      2'b00:   return f3[2] ? {24'h0, b} : {{24{b[7]}}, b};
      2'b01:   return f3[2] ? {16'h0, h} : {{16{h[15]}}, h};
      default: return word;
    endcase
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Data-memory bus between the load/store unit (master) and the data memory
// (slave).
//   request  : memory request strobe          we_re    : 1 write, 0 read
//   load     : read strobe, valid follows     mask     : byte enables
//   address  : word address                   data_in  : lane-aligned write data
//   valid    : read data valid                data_out : read word
interface load_store_unit_if #(
  parameter int ADDR_W = 8
);
  logic              request;
  logic              we_re;
  logic              load;
  logic [3:0]        mask;
  logic [ADDR_W-1:0] address;
  logic [31:0]       data_in;
  logic              valid;
  logic [31:0]       data_out;

  modport master (
    output request, we_re, load, mask, address, data_in,
    input  valid, data_out
  );

  modport slave (
    input  request, we_re, load, mask, address, data_in,
    output valid, data_out
  );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit: initiator side of the data-memory interface. Accepts one
// load or store from the MEM stage while idle, issues a single registered
// memory request, waits for valid on loads (bounded by TIMEOUT), and returns
// sign/zero-extended load data while stalling the pipeline.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   op_valid, is_store  : operation present, store(1)/load(0)
//   funct3              : RV32I size/sign code
//   eff_addr            : byte address
//   store_data          : right-aligned store value
//   mem                 : data-memory bus (master modport)
//   stall               : pipeline hold while a transfer is outstanding
//   done                : one-cycle completion pulse
//   load_result         : extended load data, held until the next load
//   misaligned          : one-cycle pulse, operation rejected
//   timeout_err         : one-cycle pulse, load aborted
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int TIMEOUT = 15
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      op_valid,
  input  logic                      is_store,
  input  logic [2:0]                funct3,
  input  logic [31:0]               eff_addr,
  input  logic [31:0]               store_data,
  load_store_unit_if.master         mem,
  output logic                      stall,
  output logic                      done,
  output logic [31:0]               load_result,
  output logic                      misaligned,
  output logic                      timeout_err
);

  localparam int CNT_W = ($clog2(TIMEOUT + 1) > 4) ? $clog2(TIMEOUT + 1) : 4;

  lsu_state_t       state;
  logic             op_store;
  logic [2:0]       op_f3;
  logic [1:0]       op_lane;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;

  logic unused_addr_hi;
  assign unused_addr_hi = ^eff_addr[31:ADDR_W+2];

  assign cnt_inc = cnt + CNT_W'(1);

  // Every output is registered, so each one is loaded on the edge that
  // enters the state it belongs to (e.g. request on IDLE->REQ, done on
  // entry to DONE) and cleared on the edge that leaves it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      op_store     <= 1'b0;
      op_f3        <= '0;
      op_lane      <= '0;
      cnt          <= '0;
      mem.request  <= 1'b0;
      mem.we_re    <= 1'b0;
      mem.load     <= 1'b0;
      mem.mask     <= '0;
      mem.address  <= '0;
      mem.data_in  <= '0;
      stall        <= 1'b0;
      done         <= 1'b0;
      load_result  <= '0;
      misaligned   <= 1'b0;
      timeout_err  <= 1'b0;
    end else begin
      done        <= 1'b0;
      misaligned  <= 1'b0;
      timeout_err <= 1'b0;
      case (state)
        S_IDLE: begin
          if (op_valid) begin
            if (is_misaligned(funct3, eff_addr[1:0])) begin
              misaligned <= 1'b1;
            end else begin
              op_store    <= is_store;
              op_f3       <= funct3;
              op_lane     <= eff_addr[1:0];
              mem.request <= 1'b1;
              mem.we_re   <= is_store;
              mem.load    <= ~is_store;
              mem.mask    <= mask_gen(funct3, eff_addr[1:0]);
              mem.address <= eff_addr[ADDR_W+1:2];
              mem.data_in <= is_store ? store_align(funct3, store_data) : '0;
              stall       <= 1'b1;
              state       <= S_REQ;
            end
          end
        end
        S_REQ: begin
          mem.request <= 1'b0;
          mem.we_re   <= 1'b0;
          mem.load    <= 1'b0;
          cnt         <= '0;
          if (op_store) begin
            done  <= 1'b1;
            stall <= 1'b0;
            state <= S_DONE;
          end else begin
            state <= S_WAIT;
          end
        end
        S_WAIT: begin
          // valid takes priority over the timeout in the same cycle
          if (mem.valid) begin
            load_result <= load_extend(op_f3, op_lane, mem.data_out);
            done        <= 1'b1;
            stall       <= 1'b0;
            state       <= S_DONE;
          end else begin
            cnt <= cnt_inc;
            if (cnt_inc == CNT_W'(TIMEOUT)) begin
              timeout_err <= 1'b1;
              load_result <= '0;
              done        <= 1'b1;
              stall       <= 1'b0;
              state       <= S_DONE;
            end
          end
        end
        S_DONE: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Initiator side of the data-memory interface. Takes one load or store per request from the pipeline MEM stage, drives request/we_re/load/mask/address/data_in to the data memory, and waits for valid on loads.
- Returns sign- or zero-extended load data and stalls the pipeline while a transfer is outstanding.
- Sits between the execute/MEM stage register and the data memory block.

Parameters:
- ADDR_W, 8, memory word-address width; memory address = eff_addr[ADDR_W+1:2]
- TIMEOUT, 15, max WAIT cycles for valid before an error abort (4-bit counter minimum)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, synchronous, active-high
- op_valid  in  1  MEM-stage operation present, accepted only in IDLE
- is_store  in  1  1 = store, 0 = load
- funct3  in  3  RV32I size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
- eff_addr  in  32  byte address
- store_data  in  32  rs2 value, right-aligned
- request  out  1  memory request strobe
- we_re  out  1  1 = write, 0 = read
- load  out  1  read strobe; memory answers with valid one cycle later
- mask  out  4  byte enables, bit i = byte lane i
- address  out  ADDR_W  word address
- data_in  out  32  lane-aligned write data
- valid  in  1  memory read-data valid
- data_out  in  32  memory read word
- stall  out  1  hold pipeline
- done  out  1  one-cycle completion pulse
- load_result  out  32  extended load data, held until next load done
- misaligned  out  1  one-cycle pulse, op rejected
- timeout_err  out  1  one-cycle pulse, load aborted

Behaviour:
- Reset: state IDLE; all outputs 0, including load_result and the timeout counter. Reset mid-transfer drops the op; no request is issued on the next cycle.
- All memory-side outputs are registered.
- FSM states: IDLE, REQ, WAIT, DONE.
- IDLE:
  - If op_valid and aligned: latch the op, go to REQ, and assert stall from the following cycle.
  - If op_valid and misaligned: pulse misaligned next cycle, stay IDLE, no request. Misaligned means H/HU with addr[0]=1, or W with addr[1:0]!=0.
- REQ (one cycle):
  - request=1, address, mask.
  - Store: we_re=1, load=0, data_in = store_data shifted to lane; next state DONE.
  - Load: we_re=0, load=1; next state WAIT; clear timeout counter.
- WAIT:
  - request/load are 0.
  - If valid: select lanes from data_out by latched addr[1:0], extend per funct3 into load_result, go to DONE.
  - Otherwise increment the counter. When count==TIMEOUT: pulse timeout_err, set load_result=0, go to DONE.
- DONE: done=1 for one cycle, stall deasserts in this same cycle, go to IDLE.
  - A new op_valid is accepted next cycle. The pipeline advances on the DONE edge.
- stall=1 in REQ and WAIT only.
- Nominal latency, op_valid accepted to done:
  - Store: 2 cycles.
  - Load: 3 cycles (REQ, WAIT with valid, DONE).
- Mask and lane alignment:
  - B: mask = 1<<a[1:0]; data_in = {4{sd[7:0]}}.
  - H: mask = 0011 or 1100; data_in = {2{sd[15:0]}}.
  - W: mask = 1111; data_in = sd.
  - Loads drive the same mask.
- Extension: B/H sign-extend from bit 7/15; BU/HU zero-extend; W passes through.
- funct3 codes 011, 110, 111 are treated as W.
- valid outside WAIT is ignored. A valid arriving in the same cycle the counter reaches TIMEOUT wins: data is captured, no error.

Decomposition:
- Shared package lsu_pkg holds:
  - funct3 constants F3_LB/LH/LW/LBU/LHU/SB/SH/SW
  - state typedef lsu_state_t
  - function mask_gen(funct3, addr[1:0])
  - function load_extend(funct3, addr[1:0], word)
- No sub-module: FSM plus datapath in one file.

Test Plan:
- Store SW addr 0x0000_0010, data 0xDEADBEEF -> REQ cycle shows request=1, we_re=1, mask=1111, address=0x04, data_in=0xDEADBEEF; done 2 cycles after accept; stall high 1 cycle.
- SB addr 0x13, data 0x000000A5 -> mask=1000, data_in=0xA5A5A5A5, address=0x04.
- LB addr 0x11, memory returns data_out=0x0000_8000 with valid in the WAIT cycle -> load_result=0xFFFF_FF80; LBU on the same word -> 0x0000_0080; LHU addr 0x12 with data_out=0x8001_0000 -> 0x0000_8001; done 3 cycles after accept.
- LW addr 0x06 -> misaligned pulse next cycle, request never asserted, stall stays 0, state IDLE.
- LW with valid held 0 -> timeout_err pulses after TIMEOUT=15 WAIT cycles, load_result=0, done pulses, stall drops; a back-to-back SW accepted the cycle after done issues normally.
- rst asserted during WAIT -> next cycle all outputs 0, state IDLE; a late valid is ignored; a subsequent op completes normally.
